// File: rtl/scaler_pkg.sv
// Shared sizes and the per-axis nearest-neighbour mapping for the mono downscaler.
package scaler_pkg;

  localparam int unsigned DEF_INPUT_WIDTH   = 800;
  localparam int unsigned DEF_INPUT_HEIGHT  = 600;
  localparam int unsigned DEF_OUTPUT_WIDTH  = 512;
  localparam int unsigned DEF_OUTPUT_HEIGHT = 342;

  localparam int unsigned IN_X_W  = $clog2(DEF_INPUT_WIDTH);
  localparam int unsigned IN_Y_W  = $clog2(DEF_INPUT_HEIGHT);
  localparam int unsigned OUT_X_W = $clog2(DEF_OUTPUT_WIDTH);
  localparam int unsigned OUT_Y_W = $clog2(DEF_OUTPUT_HEIGHT);

  // Returns {idx, sel}: idx = floor(c*O/I); sel marks the first input coordinate landing on idx.
  function automatic logic [32:0] axis_map(input logic [31:0] c,
                                           input int unsigned in_size,
                                           input int unsigned out_size);
    logic [63:0] prod;
    prod = 64'(c) * 64'(out_size);
    return {32'(prod / 64'(in_size)), (prod % 64'(in_size)) < 64'(out_size)};
  endfunction

endpackage

// File: rtl/scaler_axis_map.sv
// Combinational coordinate mapper for one axis: output index, first-hit select, range check.
module scaler_axis_map
  import scaler_pkg::*;
#(
  parameter int unsigned IN_SIZE  = DEF_INPUT_WIDTH,
  parameter int unsigned OUT_SIZE = DEF_OUTPUT_WIDTH
) (
  input  logic [$clog2(IN_SIZE)-1:0]  c,
  output logic [$clog2(OUT_SIZE)-1:0] idx_c,
  output logic                        sel_c,
  output logic                        in_range_c
);

  localparam int unsigned OUT_W = $clog2(OUT_SIZE);

  assign idx_c      = OUT_W'(axis_map(32'(c), IN_SIZE, OUT_SIZE) >> 1);
  assign sel_c      = 1'(axis_map(32'(c), IN_SIZE, OUT_SIZE));
  assign in_range_c = 32'(c) < IN_SIZE;

endmodule

// File: rtl/scaler.sv
// Nearest-neighbour decimating downscaler: forwards the first input pixel hitting each output pixel.
module scaler
  import scaler_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH   = DEF_INPUT_WIDTH,
  parameter int unsigned INPUT_HEIGHT  = DEF_INPUT_HEIGHT,
  parameter int unsigned OUTPUT_WIDTH  = DEF_OUTPUT_WIDTH,
  parameter int unsigned OUTPUT_HEIGHT = DEF_OUTPUT_HEIGHT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable_in,
  input  logic                              mono_pixel_in,
  input  logic [$clog2(INPUT_WIDTH)-1:0]    input_x,
  input  logic [$clog2(INPUT_HEIGHT)-1:0]   input_y,
  output logic                              scaled_mono_pixel,
  output logic                              scaled_write_enable,
  output logic [$clog2(OUTPUT_WIDTH)-1:0]   scaled_write_x,
  output logic [$clog2(OUTPUT_HEIGHT)-1:0]  scaled_write_y
);

  logic [$clog2(OUTPUT_WIDTH)-1:0]  idx_x_c;
  logic [$clog2(OUTPUT_HEIGHT)-1:0] idx_y_c;
  logic sel_x_c, sel_y_c, in_range_x_c, in_range_y_c;
  logic write_c;

  scaler_axis_map #(.IN_SIZE(INPUT_WIDTH), .OUT_SIZE(OUTPUT_WIDTH)) u_map_x (
    .c          (input_x),
    .idx_c      (idx_x_c),
    .sel_c      (sel_x_c),
    .in_range_c (in_range_x_c)
  );

  scaler_axis_map #(.IN_SIZE(INPUT_HEIGHT), .OUT_SIZE(OUTPUT_HEIGHT)) u_map_y (
    .c          (input_y),
    .idx_c      (idx_y_c),
    .sel_c      (sel_y_c),
    .in_range_c (in_range_y_c)
  );

  assign write_c = enable_in && in_range_x_c && in_range_y_c && sel_x_c && sel_y_c;

  // Address/pixel hold between writes; the strobe is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scaled_write_enable <= 1'b0;
      scaled_mono_pixel   <= 1'b0;
      scaled_write_x      <= '0;
      scaled_write_y      <= '0;
    end else begin
      scaled_write_enable <= write_c;
      if (write_c) begin
        scaled_mono_pixel <= mono_pixel_in;
        scaled_write_x    <= idx_x_c;
        scaled_write_y    <= idx_y_c;
      end
    end
  end

endmodule

// File: tb/tb_scaler.sv
// Self-checking bench: default 800x600->512x342 instance plus a small 50x24->32x24 instance for a full raster.
module tb_scaler;

  localparam int IW = 800, IH = 600, OW = 512, OH = 342;
  localparam int SIW = 50, SIH = 24, SOW = 32, SOH = 24;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       en_a, pix_a, opix_a, owe_a;
  logic [9:0] x_a, y_a;
  logic [8:0] ox_a, oy_a;
  logic       en_b, pix_b, opix_b, owe_b;
  logic [5:0] x_b;
  logic [4:0] y_b, ox_b, oy_b;

  scaler dut_a (
    .clk(clk), .reset(reset), .enable_in(en_a), .mono_pixel_in(pix_a),
    .input_x(x_a), .input_y(y_a), .scaled_mono_pixel(opix_a),
    .scaled_write_enable(owe_a), .scaled_write_x(ox_a), .scaled_write_y(oy_a)
  );

  scaler #(.INPUT_WIDTH(SIW), .INPUT_HEIGHT(SIH), .OUTPUT_WIDTH(SOW), .OUTPUT_HEIGHT(SOH)) dut_b (
    .clk(clk), .reset(reset), .enable_in(en_b), .mono_pixel_in(pix_b),
    .input_x(x_b), .input_y(y_b), .scaled_mono_pixel(opix_b),
    .scaled_write_enable(owe_b), .scaled_write_x(ox_b), .scaled_write_y(oy_b)
  );

  int checks = 0;
  int errors = 0;
  int exp_we[2], exp_x[2], exp_y[2], exp_pix[2];
  int cnt_a, last_xa, last_ya;
  int cnt_b, last_xb, last_yb;
  int seen_b[SOW*SOH];

  function automatic int map_idx(input int c, input int in_sz, input int out_sz);
    return int'((longint'(c) * longint'(out_sz)) / longint'(in_sz));
  endfunction

  // An input coordinate is kept when it is the first one to land on its output index.
  function automatic bit first_hit(input int c, input int in_sz, input int out_sz);
    return (c == 0) || (map_idx(c, in_sz, out_sz) != map_idx(c - 1, in_sz, out_sz));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model(input int k, input int en, input int pix, input int x, input int y);
    int iw, ih, ow, oh;
    iw = (k == 0) ? IW : SIW;  ih = (k == 0) ? IH : SIH;
    ow = (k == 0) ? OW : SOW;  oh = (k == 0) ? OH : SOH;
    if (reset !== 1'b1) begin
      exp_we[k] = 0; exp_x[k] = 0; exp_y[k] = 0; exp_pix[k] = 0;
    end else if (en != 0 && x < iw && y < ih && first_hit(x, iw, ow) && first_hit(y, ih, oh)) begin
      exp_we[k] = 1; exp_x[k] = map_idx(x, iw, ow); exp_y[k] = map_idx(y, ih, oh); exp_pix[k] = pix;
    end else begin
      exp_we[k] = 0;
    end
  endtask

  // One clock: drive DUT d (other DUT idle), update the model at the edge, check both at negedge.
  task automatic step(input string tag, input int d, input int en, input int pix, input int x, input int y);
    en_a = (d == 0) ? 1'(en) : 1'b0; pix_a = 1'(pix); x_a = 10'(x); y_a = 10'(y);
    en_b = (d == 1) ? 1'(en) : 1'b0; pix_b = 1'(pix); x_b = 6'(x);  y_b = 5'(y);
    @(posedge clk);
    model(0, (d == 0) ? en : 0, pix, x, y);
    model(1, (d == 1) ? en : 0, pix, x, y);
    @(negedge clk);
    chk({tag, ".a.we"}, 32'(owe_a), exp_we[0]);
    chk({tag, ".a.x"}, 32'(ox_a), exp_x[0]);
    chk({tag, ".a.y"}, 32'(oy_a), exp_y[0]);
    chk({tag, ".a.pix"}, 32'(opix_a), exp_pix[0]);
    chk({tag, ".b.we"}, 32'(owe_b), exp_we[1]);
    chk({tag, ".b.x"}, 32'(ox_b), exp_x[1]);
    chk({tag, ".b.y"}, 32'(oy_b), exp_y[1]);
    chk({tag, ".b.pix"}, 32'(opix_b), exp_pix[1]);
    if (owe_a === 1'b1) begin cnt_a++; last_xa = int'(ox_a); last_ya = int'(oy_a); end
    if (owe_b === 1'b1) begin
      cnt_b++; last_xb = int'(ox_b); last_yb = int'(oy_b);
      if (int'(ox_b) < SOW && int'(oy_b) < SOH) seen_b[int'(oy_b) * SOW + int'(ox_b)]++;
    end
  endtask

  initial begin
    int bad;
    en_a = 0; pix_a = 0; x_a = 0; y_a = 0;
    en_b = 0; pix_b = 0; x_b = 0; y_b = 0;
    reset = 1'b0;
    @(negedge clk);
    step("reset", 0, 0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step("idle", 0, 0, 0, 0, 0);

    step("p100_150", 0, 1, 1, 100, 150);
    chk("p100_150.const_x", 32'(ox_a), 32'd64);
    chk("p100_150.const_y", 32'(oy_a), 32'd85);
    step("hold", 0, 0, 0, 0, 0);
    chk("hold.const_x", 32'(ox_a), 32'd64);
    chk("hold.const_pix", 32'(opix_a), 32'd1);
    step("p200_300", 0, 1, 0, 200, 300);
    chk("p200_300.const_x", 32'(ox_a), 32'd128);
    chk("p200_300.const_y", 32'(oy_a), 32'd171);
    step("col1", 0, 1, 1, 1, 0);
    chk("col1.const_we", 32'(owe_a), 32'd0);
    step("col2", 0, 1, 1, 2, 0);
    chk("col2.const_x", 32'(ox_a), 32'd1);
    step("oor800", 0, 1, 1, 800, 0);
    chk("oor800.const_we", 32'(owe_a), 32'd0);

    // Reset asserted together with a selected pixel.
    reset = 1'b0;
    step("rst_mid", 0, 1, 1, 0, 0);
    chk("rst_mid.const_we", 32'(owe_a), 32'd0);
    reset = 1'b1;
    step("after_rst", 0, 1, 1, 0, 0);

    // Big instance: row 0 and row 599 produce full output lines, row 598 none.
    cnt_a = 0;
    for (int x = 0; x < IW; x++) step("row0", 0, 1, x & 1, x, 0);
    chk("row0.count", 32'(cnt_a), 32'd512);
    cnt_a = 0;
    for (int x = 0; x < IW; x++) step("row598", 0, 1, 1, x, 598);
    chk("row598.count", 32'(cnt_a), 32'd0);
    for (int x = 0; x < IW; x++) step("row599", 0, 1, (x >> 2) & 1, x, 599);
    chk("row599.count", 32'(cnt_a), 32'd512);
    chk("row599.last_x", 32'(last_xa), 32'd511);
    chk("row599.last_y", 32'(last_ya), 32'd341);

    // Small instance: full raster, x decimated and y 1:1.
    cnt_b = 0;
    for (int i = 0; i < SOW*SOH; i++) seen_b[i] = 0;
    for (int y = 0; y < SIH; y++)
      for (int x = 0; x < SIW; x++)
        step("raster", 1, 1, (x ^ y) & 1, x, y);
    chk("raster.count", 32'(cnt_b), 32'(SOW*SOH));
    bad = 0;
    for (int i = 0; i < SOW*SOH; i++) if (seen_b[i] != 1) bad++;
    chk("raster.once", 32'(bad), 32'd0);
    chk("raster.last_x", 32'(last_xb), 32'(SOW-1));
    chk("raster.last_y", 32'(last_yb), 32'(SOH-1));

    // Random mix on both instances, including out-of-range coordinates and idle cycles.
    for (int i = 0; i < 3000; i++) begin
      int d;
      d = int'($urandom_range(1, 0));
      if (d == 0)
        step("rand", 0, ($urandom_range(3, 0) != 0) ? 1 : 0, int'($urandom_range(1, 0)),
             int'($urandom_range(899, 0)), int'($urandom_range(674, 0)));
      else
        step("rand", 1, ($urandom_range(3, 0) != 0) ? 1 : 0, int'($urandom_range(1, 0)),
             int'($urandom_range(63, 0)), int'($urandom_range(31, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
